// File: rtl/nmos_switch_arbiter_if.sv
// rtl/nmos_switch_arbiter_if.sv - request/gate-control bundle between requesters and the switch arbiter
interface nmos_switch_arbiter_if #(
    parameter int N = 4
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req;
    logic [N-1:0]    ctl;
    logic [ID_W-1:0] gnt_id;
    logic            busy;
    logic            expire;

    modport master (
        output req,
        input  ctl,
        input  gnt_id,
        input  busy,
        input  expire
    );

    modport slave (
        input  req,
        output ctl,
        output gnt_id,
        output busy,
        output expire
    );
endinterface

// File: rtl/nmos_switch_arbiter.sv
// rtl/nmos_switch_arbiter.sv - round-robin owner of a shared net via N nmos pass switches, hold limit and break-before-make gap
module nmos_switch_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int GAP      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    nmos_switch_arbiter_if.slave  bus
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;
    localparam int HC_W = $clog2(MAX_HOLD + 1);
    localparam int GC_W = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BREAK = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [N-1:0]    r_ctl, w_ctl_nxt;
    logic [ID_W-1:0] r_gnt_id, w_gnt_nxt;
    logic            r_busy;
    logic            r_expire, w_expire_nxt;
    logic [ID_W-1:0] r_ptr, w_ptr_nxt;
    logic [HC_W-1:0] r_hold_cnt, w_hold_nxt;
    logic [GC_W-1:0] r_gap_cnt, w_gap_nxt;

    logic            w_win_valid;
    logic [ID_W-1:0] w_win_id;
    logic [ID_W:0]   w_sum;
    logic [N-1:0]    w_onehot;
    logic            w_owner_req;
    logic            w_hold_max;
    logic            w_gap_last;
    logic [ID_W-1:0] w_ptr_inc;

    // Scan downward so the last hit is the first requester at or after ptr.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_id    = '0;
        w_sum       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_ptr} + (ID_W + 1)'(i);
            if (w_sum >= (ID_W + 1)'(N))
                w_sum = w_sum - (ID_W + 1)'(N);
            if (bus.req[w_sum[ID_W-1:0]]) begin
                w_win_valid = 1'b1;
                w_win_id    = w_sum[ID_W-1:0];
            end
        end
    end

    assign w_onehot    = {{(N-1){1'b0}}, 1'b1} << w_win_id;
    assign w_owner_req = bus.req[r_gnt_id];
    assign w_hold_max  = (r_hold_cnt == HC_W'(MAX_HOLD));
    assign w_gap_last  = (r_gap_cnt == GC_W'(GAP));
    assign w_ptr_inc   = (r_gnt_id == ID_W'(N - 1)) ? '0 : r_gnt_id + 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_ctl_nxt    = r_ctl;
        w_gnt_nxt    = r_gnt_id;
        w_expire_nxt = 1'b0;
        w_ptr_nxt    = r_ptr;
        w_hold_nxt   = r_hold_cnt;
        w_gap_nxt    = r_gap_cnt;

        case (r_state)
            GRANT: begin
                if (!w_owner_req || w_hold_max) begin
                    w_state_nxt  = BREAK;
                    w_ctl_nxt    = '0;
                    w_gnt_nxt    = '0;
                    w_hold_nxt   = '0;
                    w_gap_nxt    = GC_W'(1);
                    w_ptr_nxt    = w_ptr_inc;
                    w_expire_nxt = w_owner_req && w_hold_max;
                end else begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            IDLE, BREAK: begin
                if (r_state == BREAK && !w_gap_last) begin
                    w_gap_nxt = r_gap_cnt + 1'b1;
                end else if (w_win_valid) begin
                    w_state_nxt = GRANT;
                    w_ctl_nxt   = w_onehot;
                    w_gnt_nxt   = w_win_id;
                    w_hold_nxt  = HC_W'(1);
                    w_gap_nxt   = '0;
                end else begin
                    w_state_nxt = IDLE;
                    w_ctl_nxt   = '0;
                    w_gnt_nxt   = '0;
                    w_gap_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ctl_nxt   = '0;
                w_gnt_nxt   = '0;
                w_hold_nxt  = '0;
                w_gap_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ctl      <= '0;
            r_gnt_id   <= '0;
            r_busy     <= 1'b0;
            r_expire   <= 1'b0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ctl      <= w_ctl_nxt;
            r_gnt_id   <= w_gnt_nxt;
            r_busy     <= |w_ctl_nxt;
            r_expire   <= w_expire_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gap_cnt  <= w_gap_nxt;
        end
    end

    assign bus.ctl    = r_ctl;
    assign bus.gnt_id = r_gnt_id;
    assign bus.busy   = r_busy;
    assign bus.expire = r_expire;
endmodule

// File: tb/tb_nmos_switch_arbiter.sv
// tb/tb_nmos_switch_arbiter.sv - directed vector bench for nmos_switch_arbiter at N=4, MAX_HOLD=8, GAP=1
module tb_nmos_switch_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [3:0] prev_ctl;

    nmos_switch_arbiter_if #(.N(4)) bus ();

    nmos_switch_arbiter #(.N(4), .MAX_HOLD(8), .GAP(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] ctl;
        int         gnt;
        logic       expire;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string nm, input logic [3:0] ec, input int eg, input logic ee);
        chk({nm, "_ctl"}, int'(bus.ctl), int'(ec));
        chk({nm, "_gnt"}, int'(bus.gnt_id), eg);
        chk({nm, "_busy"}, int'(bus.busy), int'(|ec));
        chk({nm, "_expire"}, int'(bus.expire), int'(ee));
    endtask

    task automatic step(input string nm, input logic [3:0] r, input logic [3:0] ec, input int eg, input logic ee);
        bus.req = r;
        @(posedge clk);
        #1;
        check_outs(nm, ec, eg, ee);
    endtask

    // Invariants sampled every cycle on the falling edge.
    always @(negedge clk) begin
        chk("inv_onehot", int'($countones(bus.ctl) <= 1), 1);
        chk("inv_busy", int'(bus.busy), int'(|bus.ctl));
        chk("inv_bbm", int'(prev_ctl != 4'b0 && bus.ctl != 4'b0 && bus.ctl != prev_ctl), 0);
        prev_ctl = bus.ctl;
    end

    vec_t tbl[12];
    logic [3:0] one;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        prev_ctl = 4'b0;
        one      = 4'b0001;
        tbl[0]  = '{4'b0100, 4'b0100, 2, 1'b0};
        tbl[1]  = '{4'b0100, 4'b0100, 2, 1'b0};
        tbl[2]  = '{4'b0100, 4'b0100, 2, 1'b0};
        tbl[3]  = '{4'b0000, 4'b0000, 0, 1'b0};
        tbl[4]  = '{4'b0000, 4'b0000, 0, 1'b0};
        tbl[5]  = '{4'b0011, 4'b0001, 0, 1'b0};
        tbl[6]  = '{4'b0010, 4'b0000, 0, 1'b0};
        tbl[7]  = '{4'b0010, 4'b0010, 1, 1'b0};
        tbl[8]  = '{4'b1000, 4'b0000, 0, 1'b0};
        tbl[9]  = '{4'b1001, 4'b1000, 3, 1'b0};
        tbl[10] = '{4'b0001, 4'b0000, 0, 1'b0};
        tbl[11] = '{4'b0000, 4'b0000, 0, 1'b0};

        rst     = 1'b1;
        bus.req = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 4'b0, 0, 1'b0);
        rst = 1'b0;

        for (int v = 0; v < 12; v++)
            step($sformatf("vec%0d", v), tbl[v].req, tbl[v].ctl, tbl[v].gnt, tbl[v].expire);

        // All four requesting: rotate 0,1,2,3,0 with expire on each hold limit.
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 8; c++)
                step("all_on", 4'hF, one << (r % 4), r % 4, 1'b0);
            step("all_gap", 4'hF, 4'b0, 0, 1'b1);
        end
        step("all_idle", 4'b0, 4'b0, 0, 1'b0);

        // Requesters 1 and 3 alternate.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 8; c++)
                step("pair_on", 4'b1010, one << ((r % 2 == 0) ? 1 : 3), (r % 2 == 0) ? 1 : 3, 1'b0);
            step("pair_gap", 4'b1010, 4'b0, 0, 1'b1);
        end
        step("pair_idle", 4'b0, 4'b0, 0, 1'b0);

        // Owner drops on the same edge the hold limit is reached: no expire.
        for (int c = 0; c < 8; c++)
            step("lim_on", 4'b0100, 4'b0100, 2, 1'b0);
        step("lim_drop", 4'b0000, 4'b0000, 0, 1'b0);
        step("lim_regrant", 4'b0100, 4'b0100, 2, 1'b0);
        step("lim_hold", 4'b0100, 4'b0100, 2, 1'b0);

        // Reset mid-grant drops the switch without a clock edge.
        rst = 1'b1;
        #2;
        check_outs("rst_async", 4'b0, 0, 1'b0);
        rst = 1'b0;
        step("rst_first", 4'b1000, 4'b1000, 3, 1'b0);
        step("rst_hold", 4'b1000, 4'b1000, 3, 1'b0);
        step("rst_drop", 4'b0000, 4'b0000, 0, 1'b0);
        step("rst_idle", 4'b0000, 4'b0000, 0, 1'b0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
